seq_magnitude_comparator: RTL and testbench

- Parametrised, bit-serial, MSB-first magnitude comparator; successor to the fixed 4-bit combinational agb/eq/alb comparator.
- Operands and mode are latched on a start pulse.
- One bit pair is scanned per clock, with early termination at the first differing bit.
- Registered agb/eq/alb flags and a one-cycle done pulse are produced; used by datapath control that needs wide or signed compares without a wide combinational compare tree.

---
 rtl/seq_magnitude_comparator_if.sv | 36 +++
 rtl/seq_magnitude_comparator.sv | 145 ++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
//
// Signals:
//   start        request a compare (driven by the requester)
//   a, b         operands, WIDTH bits (driven by the requester)
//   signed_mode  1 = two's-complement compare (driven by the requester)
//   busy         compare in progress (driven by the comparator)
//   done         one-cycle result-written pulse (driven by the comparator)
//   agb/eq/alb   registered A>B / A==B / A<B flags (driven by the comparator)
//
// Modports:
//   master  requester side
//   slave   comparator side
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             agb;
    logic             eq;
    logic             alb;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, agb, eq, alb
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, agb, eq, alb
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial, MSB-first magnitude comparator.
//
// Operands and mode are captured on an accepted start pulse. One bit pair is
// examined per clock starting at the MSB; the scan stops at the first
// differing bit (or after bit 0 when the operands are equal), at which point
// the agb/eq/alb flags are written and done pulses for one cycle.
//
// Parameters:
//   WIDTH      operand width, 2..32
//   SIGNED_EN  1 = honour signed_mode, 0 = always compare unsigned
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   request/result bundle (slave side): start, a, b, signed_mode in;
//         busy, done, agb, eq, alb out
module seq_magnitude_comparator #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    seq_magnitude_comparator_if.slave    bus
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             agb_q, agb_d;
    logic             eq_q, eq_d;
    logic             alb_q, alb_d;

    logic             a_bit;
    logic             b_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        agb_d   = agb_q;
        eq_d    = eq_q;
        alb_d   = alb_q;

        case (state_q)
            IDLE: begin
                // Flags are left alone here so the previous result stays
                // visible until the new one is written.
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sm_d    = bus.signed_mode & SIGNED_EN;
                    idx_d   = IDX_MSB;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (a_bit != b_bit) begin
                    // A differing sign bit in signed mode flips the sense:
                    // the operand with a 1 there is the negative one. Below
                    // the MSB the sign bits are known equal, so plain
                    // unsigned ordering applies in either mode.
                    if ((idx_q == IDX_MSB) && sm_q) begin
                        agb_d = b_bit;
                        alb_d = a_bit;
                    end else begin
                        agb_d = a_bit;
                        alb_d = b_bit;
                    end
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    agb_d   = 1'b0;
                    eq_d    = 1'b1;
                    alb_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Never wraps: idx == 0 always terminates above.
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            agb_q   <= 1'b0;
            eq_q    <= 1'b0;
            alb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            agb_q   <= agb_d;
            eq_q    <= eq_d;
            alb_q   <= alb_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.agb  = agb_q;
    assign bus.eq   = eq_q;
    assign bus.alb  = alb_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: an 8-bit instance for the
// hand-computed scenarios and a 4-bit instance swept over all operand pairs.
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    always #5 clk = ~clk;

    seq_magnitude_comparator_if #(.WIDTH(8)) bus8 ();
    seq_magnitude_comparator_if #(.WIDTH(4)) bus4 ();

    seq_magnitude_comparator #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    seq_magnitude_comparator #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] flags8();
        return {bus8.agb, bus8.eq, bus8.alb};
    endfunction

    function automatic logic [2:0] flags4();
        return {bus4.agb, bus4.eq, bus4.alb};
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        bus8.a           = a;
        bus8.b           = b;
        bus8.signed_mode = sm;
        bus8.start       = 1'b1;
        tick();
        bus8.start       = 1'b0;
    endtask

    task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        bus4.a           = a;
        bus4.b           = b;
        bus4.signed_mode = sm;
        bus4.start       = 1'b1;
        tick();
        bus4.start       = 1'b0;
    endtask

    // Edges from the accepting edge until done is seen (bounded).
    task automatic wait8(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus8.done !== 1'b1) && (n < 40));
    endtask

    task automatic wait4(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus4.done !== 1'b1) && (n < 20));
    endtask

    initial begin
        logic       exp_gt;
        logic       exp_lt;
        logic [2:0] exp_flags;
        logic [3:0] xa;
        logic [3:0] xb;
        logic [3:0] diff;
        int         exp_lat;

        rst              = 1'b1;
        bus8.start       = 1'b0;
        bus8.a           = '0;
        bus8.b           = '0;
        bus8.signed_mode = 1'b0;
        bus4.start       = 1'b0;
        bus4.a           = '0;
        bus4.b           = '0;
        bus4.signed_mode = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy8",  32'(bus8.busy), 32'd0);
        check("rst_done8",  32'(bus8.done), 32'd0);
        check("rst_flags8", 32'(flags8()),  32'd0);
        check("rst_flags4", 32'(flags4()),  32'd0);

        // start under reset is ignored
        bus8.start = 1'b1;
        tick();
        check("rst_prio_busy", 32'(bus8.busy), 32'd0);
        bus8.start = 1'b0;
        rst = 1'b0;
        tick();

        // 1: MSB differs, unsigned
        start8(8'h80, 8'h00, 1'b0);
        check("t1_busy_acc", 32'(bus8.busy), 32'd1);
        check("t1_done_acc", 32'(bus8.done), 32'd0);
        wait8(lat);
        check("t1_done",  32'(bus8.done), 32'd1);
        check("t1_busy",  32'(bus8.busy), 32'd0);
        check("t1_lat",   32'(lat),       32'd1);
        check("t1_flags", 32'(flags8()),  32'b100);
        tick();
        check("t1_done_pulse", 32'(bus8.done), 32'd0);
        check("t1_flags_hold", 32'(flags8()),  32'b100);

        // 2: LSB differs, then equal
        start8(8'h01, 8'h00, 1'b0);
        wait8(lat);
        check("t2a_lat",   32'(lat),      32'd8);
        check("t2a_flags", 32'(flags8()), 32'b100);
        tick();
        start8(8'h5A, 8'h5A, 1'b0);
        wait8(lat);
        check("t2b_lat",   32'(lat),      32'd8);
        check("t2b_flags", 32'(flags8()), 32'b010);
        tick();

        // 3: signed handling
        start8(8'h80, 8'h01, 1'b0);
        wait8(lat);
        check("t3a_lat",   32'(lat),      32'd1);
        check("t3a_flags", 32'(flags8()), 32'b100);
        tick();
        start8(8'h80, 8'h01, 1'b1);
        wait8(lat);
        check("t3b_lat",   32'(lat),      32'd1);
        check("t3b_flags", 32'(flags8()), 32'b001);
        tick();
        start8(8'hFF, 8'hFE, 1'b1);
        wait8(lat);
        check("t3c_lat",   32'(lat),      32'd8);
        check("t3c_flags", 32'(flags8()), 32'b100);
        tick();

        // 4: start while busy is ignored; back-to-back start in done cycle
        start8(8'h00, 8'h01, 1'b0);
        tick();
        bus8.a     = 8'hFF;
        bus8.b     = 8'h00;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        check("t4_busy_kept", 32'(bus8.busy), 32'd1);
        wait8(lat);
        check("t4_lat",   32'(lat + 2),   32'd8);
        check("t4_flags", 32'(flags8()),  32'b001);
        start8(8'h33, 8'h33, 1'b0);
        check("t4_b2b_busy", 32'(bus8.busy), 32'd1);
        check("t4_b2b_done", 32'(bus8.done), 32'd0);
        check("t4_b2b_hold", 32'(flags8()),  32'b001);
        wait8(lat);
        check("t4_b2b_lat",   32'(lat),      32'd8);
        check("t4_b2b_flags", 32'(flags8()), 32'b010);
        tick();

        // 5: reset mid-scan
        start8(8'h01, 8'h02, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy",  32'(bus8.busy), 32'd0);
        check("t5_done",  32'(bus8.done), 32'd0);
        check("t5_flags", 32'(flags8()),  32'd0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) lat++;
        end
        check("t5_no_done", 32'(lat), 32'd0);

        // 6: WIDTH=4 sweep, unsigned and signed
        for (int sm = 0; sm < 2; sm++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    xa = 4'(ia);
                    xb = 4'(ib);
                    if (sm != 0) begin
                        exp_gt = $signed(xa) > $signed(xb);
                        exp_lt = $signed(xa) < $signed(xb);
                    end else begin
                        exp_gt = xa > xb;
                        exp_lt = xa < xb;
                    end
                    exp_flags = {exp_gt, (xa == xb), exp_lt};
                    diff = xa ^ xb;
                    if (diff[3])      exp_lat = 1;
                    else if (diff[2]) exp_lat = 2;
                    else if (diff[1]) exp_lat = 3;
                    else              exp_lat = 4;
                    start4(xa, xb, sm[0]);
                    wait4(lat);
                    check($sformatf("t6_flags_sm%0d_a%0h_b%0h", sm, xa, xb),
                          32'(flags4()), 32'(exp_flags));
                    check($sformatf("t6_lat_sm%0d_a%0h_b%0h", sm, xa, xb),
                          32'(lat), 32'(exp_lat));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
